// File: rtl/fp_addsub_param.sv
// Multi-cycle floating-point adder/subtractor with configurable EXP_W/MAN_W format.
// Define FP_ADDSUB_SUBNORMAL_EN for gradual underflow; the default build flushes tiny values to zero.
module fp_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   oper,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic [EXP_W+MAN_W:0]   R,
  output logic [3:0]             flags,
  output logic                   ready,
  output logic                   done
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;   // {hidden, fraction, G, R, S}
  localparam int XW = EXP_W + 2;   // headroom for carry and rounding increments
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND} state_t;
  state_t state, state_nx;

  logic [W-1:0]  a_q, b_q;
  logic          op_q;
  logic          sa_p0, sb_p0, nan_p0, infa_p0, infb_p0;
  logic [XW-1:0] ea_p0, eb_p0;
  logic [SW-1:0] ma_p0, mb_p0;
  logic          sx_p1, sy_p1;
  logic [XW-1:0] ex_p1;
  logic [SW-1:0] mx_p1, my_p1;
  logic          sub_p2;
  logic [SW:0]   sum_p2;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == EMAX) && (x[MAN_W-1:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == EMAX) && (x[MAN_W-1:0] == '0);
  endfunction

  function automatic logic [XW-1:0] exp_of(input logic [W-1:0] x);
    return (x[W-2:MAN_W] == '0) ? XW'(1) : {2'b00, x[W-2:MAN_W]};
  endfunction

  function automatic logic [SW-1:0] sig_of(input logic [W-1:0] x);
    logic hid;
    hid = (x[W-2:MAN_W] != '0);
`ifdef FP_ADDSUB_SUBNORMAL_EN
    return {hid, x[MAN_W-1:0], 3'b000};
`else
    return hid ? {1'b1, x[MAN_W-1:0], 3'b000} : '0;
`endif
  endfunction

  function automatic logic [31:0] lzc(input logic [SW-1:0] v);
    lzc = 32'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = 32'(SW - 1 - i);
  endfunction

  // Round-to-nearest-even on G/R/S, then pack; returns {result, flags}.
  function automatic logic [W+3:0] round_pack(input logic s, input logic [XW-1:0] e,
                                              input logic [SW-1:0] m);
    logic [MAN_W+1:0] mr;
    logic [XW-1:0]    ef;
    logic [W-1:0]     res;
    logic             up, inx, ovf, unf;
    inx = |m[2:0];
    up  = m[2] & (m[1] | m[0] | m[3]);
    mr  = {1'b0, m[SW-1:3]} + (MAN_W+2)'(up);
    ef  = e;
    ovf = 1'b0;
    unf = 1'b0;
    if (mr[MAN_W+1]) begin
      mr = mr >> 1;
      ef = e + 1'b1;
    end
    res = {s, (mr[MAN_W] ? ef[EXP_W-1:0] : {EXP_W{1'b0}}), mr[MAN_W-1:0]};
    if (ef >= {2'b00, EMAX}) begin
      res = {s, EMAX, {MAN_W{1'b0}}};
      ovf = 1'b1;
      inx = 1'b1;
    end else if (!mr[MAN_W]) begin
`ifdef FP_ADDSUB_SUBNORMAL_EN
      unf = inx;
`else
      res = {s, {(W-1){1'b0}}};
      unf = 1'b1;
      inx = 1'b1;
`endif
    end
    return {res, 1'b0, ovf, unf, inx};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = UNPACK;
      UNPACK:  state_nx = ALIGN;
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // R is registered on entry to ROUND, so the ROUND cycle itself presents the result.
  assign ready = (state == IDLE) || (state == ROUND);
  assign done  = (state == ROUND);

  logic          swap;
  logic [XW-1:0] dexp;
  logic [31:0]   sh_al;
  logic [SW-1:0] my_sel;
  logic [2*SW-1:0] wide;
  logic [SW-1:0] my_al;

  always_comb begin
    swap   = {eb_p0, mb_p0} > {ea_p0, ma_p0};
    dexp   = swap ? (eb_p0 - ea_p0) : (ea_p0 - eb_p0);
    my_sel = swap ? ma_p0 : mb_p0;
    sh_al  = (32'(dexp) > 32'(SW - 1)) ? 32'(SW - 1) : 32'(dexp);
    wide   = {my_sel, {SW{1'b0}}} >> sh_al;
    my_al  = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_q  <= A;
      b_q  <= B;
      op_q <= oper;
    end
    // UNPACK -> ALIGN
    if (state == UNPACK) begin
      sa_p0   <= a_q[W-1];
      sb_p0   <= b_q[W-1] ^ op_q;
      ea_p0   <= exp_of(a_q);
      eb_p0   <= exp_of(b_q);
      ma_p0   <= sig_of(a_q);
      mb_p0   <= sig_of(b_q);
      nan_p0  <= is_nan(a_q) | is_nan(b_q);
      infa_p0 <= is_inf(a_q);
      infb_p0 <= is_inf(b_q);
    end
    // ALIGN -> ADD
    if (state == ALIGN) begin
      sx_p1 <= swap ? sb_p0 : sa_p0;
      sy_p1 <= swap ? sa_p0 : sb_p0;
      ex_p1 <= swap ? eb_p0 : ea_p0;
      mx_p1 <= swap ? mb_p0 : ma_p0;
      my_p1 <= my_al;
    end
    // ADD -> NORM
    if (state == ADD) begin
      sub_p2 <= sx_p1 ^ sy_p1;
      sum_p2 <= (sx_p1 ^ sy_p1) ? ({1'b0, mx_p1} - {1'b0, my_p1})
                                : ({1'b0, mx_p1} + {1'b0, my_p1});
    end
  end

  logic [31:0]   lz, lim, sh_n;
  logic [SW-1:0] m_n;
  logic [XW-1:0] e_n;
  logic [W-1:0]  res_n;
  logic [3:0]    flg_n;

  always_comb begin
    lz   = lzc(sum_p2[SW-1:0]);
    lim  = 32'(ex_p1) - 32'd1;
    sh_n = (lz < lim) ? lz : lim;
    if (sum_p2[SW]) begin
      m_n = {sum_p2[SW:2], sum_p2[1] | sum_p2[0]};
      e_n = ex_p1 + 1'b1;
    end else begin
      m_n = sum_p2[SW-1:0] << sh_n;
      e_n = ex_p1 - XW'(sh_n);
    end
    {res_n, flg_n} = round_pack(sx_p1, e_n, m_n);
    if (nan_p0) begin
      res_n = QNAN;
      flg_n = 4'b0000;
    end else if (infa_p0 && infb_p0 && (sa_p0 != sb_p0)) begin
      res_n = QNAN;
      flg_n = 4'b1000;
    end else if (infa_p0 || infb_p0) begin
      res_n = {(infa_p0 ? sa_p0 : sb_p0), EMAX, {MAN_W{1'b0}}};
      flg_n = 4'b0000;
    end else if (sum_p2 == '0) begin
      res_n = {sx_p1 & ~sub_p2, {(W-1){1'b0}}};
      flg_n = 4'b0000;
    end
  end

  // NORM -> ROUND: result and flags commit together with the done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      R     <= '0;
      flags <= '0;
    end else if (state == NORM) begin
      R     <= res_n;
      flags <= flg_n;
    end
  end

endmodule

// File: tb/tb_fp_addsub_param.sv
// Bench for fp_addsub_param (default 8/23 format): directed table, exact-integer reference model, timing sequences.
module tb_fp_addsub_param;
  logic        clk = 1'b0;
  logic        reset, start, oper;
  logic [31:0] A, B, R;
  logic [3:0]  flags;
  logic        ready, done;

  int vecs = 0;
  int errs = 0;

  fp_addsub_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .start(start), .oper(oper),
    .A(A), .B(B), .R(R), .flags(flags), .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Operand magnitude as an exact integer in units of 2^-149.
  function automatic logic [299:0] mag_of(input logic [31:0] x);
    if (x[30:23] == 8'd0) begin
`ifdef FP_ADDSUB_SUBNORMAL_EN
      return 300'(x[22:0]);
`else
      return '0;
`endif
    end
    return 300'({1'b1, x[22:0]}) << (x[30:23] - 8'd1);
  endfunction

  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic sa, sb, na, nb, ia, ib, s, up, inx;
    logic [299:0] ma, mb, mag, keep, rem, half;
    int p, sh;
    logic [8:0] ee;
    sa = a[31];
    sb = b[31] ^ op;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (na || nb) return {32'h7FC00000, 4'b0000};
    if (ia && ib && (sa != sb)) return {32'h7FC00000, 4'b1000};
    if (ia) return {sa, 8'hFF, 23'd0, 4'b0000};
    if (ib) return {sb, 8'hFF, 23'd0, 4'b0000};
    ma = mag_of(a);
    mb = mag_of(b);
    if (sa == sb) begin
      mag = ma + mb; s = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; s = (ma == mb) ? 1'b0 : sa;
    end else begin
      mag = mb - ma; s = sb;
    end
    if (mag == 0) return {s, 31'd0, 4'b0000};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p < 23) begin
`ifdef FP_ADDSUB_SUBNORMAL_EN
      return {s, 8'd0, mag[22:0], 4'b0000};
`else
      return {s, 31'd0, 4'b0011};
`endif
    end
    sh   = p - 23;
    keep = mag >> sh;
    rem  = mag - (keep << sh);
    half = (sh == 0) ? '0 : (300'd1 << (sh - 1));
    inx  = (rem != 0);
    up   = (sh != 0) && ((rem > half) || ((rem == half) && keep[0]));
    keep = keep + 300'(up);
    if (keep[24]) begin
      keep = keep >> 1;
      sh++;
    end
    ee = 9'(sh + 1);
    if (ee >= 9'd255) return {s, 8'hFF, 23'd0, 4'b0101};
    return {s, ee[7:0], keep[22:0], 3'b000, inx};
  endfunction

  function automatic logic [7:0] rnd_exp();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'hFE;
      3:       return 8'h01;
      default: return 8'($urandom_range(1, 254));
    endcase
  endfunction

  // One transaction; lat is the cycle offset of done from the start cycle (-1 on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        output logic [31:0] r, output logic [3:0] f,
                        output int lat, output logic rdy_ok);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
    A = a; B = b; oper = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom; oper = 1'($urandom);
    rdy_ok = 1'b1;
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        lat = k + 1;
        if (!ready) rdy_ok = 1'b0;
        break;
      end
      if (ready) rdy_ok = 1'b0;
      @(posedge clk); #1;
    end
    r = R;
    f = flags;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r, a, b;
    logic [3:0]  f;
    logic        op, rdy_ok, seen;
    logic [35:0] m;
    logic [7:0]  ea, eb;
    int lat, last, npulse, tmp;

    tv[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
    tv[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
    tv[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
    tv[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
    tv[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
    tv[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
    tv[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
    tv[7]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
`ifdef FP_ADDSUB_SUBNORMAL_EN
    tv[8]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'b0000};
`else
    tv[8]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011};
`endif
    tv[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
    tv[10] = '{32'h40400000, 32'h00000000, 1'b0, 32'h40400000, 4'b0000};
    tv[11] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'b0000};
    tv[12] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000};
    tv[13] = '{32'hC0000000, 32'h3F800000, 1'b1, 32'hC0400000, 4'b0000};
    tv[14] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};

    reset = 1'b1; start = 1'b0; oper = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_R", R, 32'h0);
    chk("reset_flags", 32'(flags), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_ready", 32'(ready), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].op, r, f, lat, rdy_ok);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
      chk($sformatf("vec%0d_ready", i), 32'(rdy_ok), 32'd1);
      chk($sformatf("vec%0d_R", i), r, tv[i].r);
      chk($sformatf("vec%0d_flags", i), 32'(f), 32'(tv[i].f));
    end

    for (int n = 0; n < 300; n++) begin
      ea = rnd_exp();
      a  = {1'($urandom), ea, (ea == 8'hFF && $urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
      if ($urandom_range(0, 1) == 0) begin
        tmp = int'(ea) + int'($urandom_range(0, 4)) - 2;
        if (tmp < 0) tmp = 0;
        if (tmp > 255) tmp = 255;
        eb = 8'(tmp);
      end else begin
        eb = rnd_exp();
      end
      b  = {1'($urandom), eb, ($urandom_range(0, 3) == 0) ? a[22:0] : 23'($urandom)};
      op = 1'($urandom);
      m  = model(a, b, op);
      run_op(a, b, op, r, f, lat, rdy_ok);
      chk($sformatf("rand_R %h %s %h", a, op ? "-" : "+", b), r, m[35:4]);
      chk($sformatf("rand_flags %h %s %h", a, op ? "-" : "+", b), 32'(f), 32'(m[3:0]));
    end

    run_op(32'h3F800000, 32'h40000000, 1'b0, r, f, lat, rdy_ok);
    chk("pre_abort_R", r, 32'h40400000);

    // Abort a transaction with reset in its fourth cycle.
    @(negedge clk);
    A = 32'h40000000; B = 32'h40000000; oper = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = done;
    @(posedge clk); #1;
    seen |= done;
    @(posedge clk); #1;
    seen |= done;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_R", R, 32'h0);
    seen |= done;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      seen |= done;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // Start held high: one acceptance every six cycles.
    @(negedge clk);
    A = 32'h3F800000; B = 32'h40000000; oper = 1'b0; start = 1'b1;
    last = -1;
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        chk("b2b_R", R, 32'h40400000);
        if (last < 0) chk("b2b_first", 32'(k), 32'd4);
        else          chk("b2b_gap", 32'(k - last), 32'd6);
        last = k;
        npulse++;
      end
    end
    start = 1'b0;
    chk("b2b_pulses", 32'(npulse), 32'd3);
    repeat (8) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
